// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: EX-stage handshake between the pipeline and the M-extension sequencer
//   master (EX stage): drives start, funct3, srcA, srcB, flush; observes stall, busy, result, result_valid
//   slave  (sequencer): the mirror image
interface muldiv_sequencer_if #(parameter int XLEN = 32);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic            flush;
    logic            stall;
    logic            busy;
    logic [XLEN-1:0] result;
    logic            result_valid;
    modport master (output start, funct3, srcA, srcB, flush, input stall, busy, result, result_valid);
    modport slave  (input start, funct3, srcA, srcB, flush, output stall, busy, result, result_valid);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit beside the EX-stage ALU
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of muldiv_sequencer_if (start/funct3/srcA/srcB/flush in; stall/busy/result/result_valid out)
module muldiv_sequencer #(parameter int XLEN = 32) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
    logic [1:0]        r_state;
    logic [CW-1:0]     r_count;
    logic [1:0]        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [2*XLEN-1:0] r_p;
    logic [XLEN-1:0]   r_m;
    logic [XLEN-1:0]   r_result;
    logic              r_valid;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_special;
    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_pnext;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_q;
    logic [XLEN-1:0]   w_r;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_mres;
    logic [XLEN-1:0]   w_dres;
    logic              w_last;
    // Operand signedness: MUL/MULH both signed, MULHSU only A, MULHU none; DIV/REM signed when funct3[0]=0
    assign w_sa      = (bus.funct3[2] ? ~bus.funct3[0] : bus.funct3[1:0] != 2'b11) & bus.srcA[XLEN-1];
    assign w_sb      = (bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1]) & bus.srcB[XLEN-1];
    assign w_abs_a   = w_sa ? -bus.srcA : bus.srcA;
    assign w_abs_b   = w_sb ? -bus.srcB : bus.srcB;
    assign w_div0    = bus.srcB == '0;
    assign w_ovf     = ~bus.funct3[0] & (bus.srcA == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.srcB);
    // Overflow quotient equals srcA (most negative value), so srcA doubles as that result
    assign w_special = w_div0 ? (bus.funct3[1] ? bus.srcA : '1) : (bus.funct3[1] ? '0 : bus.srcA);
    // Multiply: r_p = {accumulator, remaining multiplier bits}; add into the top half, shift right
    assign w_sum     = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_m} : '0);
    assign w_pnext   = {w_sum, r_p[XLEN-1:1]};
    assign w_prod    = r_neg_q ? -w_pnext : w_pnext;
    // Divide: r_p = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    assign w_shift   = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
    assign w_trial   = w_shift - {1'b0, r_m};
    assign w_q       = {r_p[XLEN-2:0], ~w_trial[XLEN]};
    assign w_r       = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
    assign w_quo     = r_neg_q ? -w_q : w_q;
    assign w_rem     = r_neg_r ? -w_r : w_r;
    assign w_mres    = r_op == 2'b00 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    assign w_dres    = r_op[1] ? w_rem : w_quo;
    assign w_last    = r_count == CW'(XLEN-1);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_p      <= '0;
            r_m      <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.start && !bus.flush) begin
                    r_op    <= bus.funct3[1:0];
                    r_neg_q <= w_sa ^ w_sb;
                    r_neg_r <= w_sa;
                    r_count <= '0;
                    r_p     <= {{XLEN{1'b0}}, bus.funct3[2] ? w_abs_a : w_abs_b};
                    r_m     <= bus.funct3[2] ? w_abs_b : w_abs_a;
                    if (bus.funct3[2] && (w_div0 || w_ovf)) begin
                        r_state  <= S_DONE;
                        r_valid  <= 1'b1;
                        r_result <= w_special;
                    end else begin
                        r_state <= bus.funct3[2] ? S_DIV : S_MUL;
                    end
                end
                S_MUL, S_DIV: if (bus.flush) begin
                    r_state <= S_IDLE;
                end else begin
                    r_p     <= r_state == S_MUL ? w_pnext : {w_r, w_q};
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_valid  <= 1'b1;
                        r_result <= r_state == S_MUL ? w_mres : w_dres;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign bus.stall        = ~bus.flush & ((r_state == S_IDLE & bus.start) | r_state == S_MUL | r_state == S_DIV);
    assign bus.busy         = r_state != S_IDLE;
    assign bus.result       = r_result;
    // The strobe is only ever high in DONE; a flush arriving in DONE suppresses it
    assign bus.result_valid = r_valid & ~bus.flush;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    muldiv_sequencer_if #(.XLEN(32)) bus();
    muldiv_sequencer #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Called at a negedge; issues one op, ends at the negedge of the cycle after DONE
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int exp_n);
        int n = 0;
        int sc = 0;
        logic done = 1'b0;
        bus.start = 1'b1; bus.funct3 = f3; bus.srcA = a; bus.srcB = b;
        #1;
        if (bus.stall) sc++;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0; bus.srcA = $urandom; bus.srcB = $urandom;
            #1;
            if (bus.result_valid) done = 1'b1;
            else if (bus.stall) sc++;
        end
        chk({tag, " strobe"}, 32'(done), 32'd1);
        chk({tag, " cycles"}, 32'(n), 32'(exp_n));
        chk({tag, " stall_cycles"}, 32'(sc), 32'(exp_n));
        chk({tag, " stall_in_done"}, 32'(bus.stall), 32'd0);
        chk({tag, " result"}, bus.result, exp_r);
        @(negedge clk);
        #1;
        chk({tag, " strobe_once"}, 32'(bus.result_valid), 32'd0);
        chk({tag, " busy_after"}, 32'(bus.busy), 32'd0);
    endtask
    initial begin
        bus.start = 1'b0; bus.funct3 = 3'd0; bus.srcA = '0; bus.srcB = '0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset result", bus.result, 32'd0);
        chk("reset valid", 32'(bus.result_valid), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset stall", 32'(bus.stall), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        run_op("MUL 7x-3",      3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33);
        run_op("MULH min*min",  3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 33);
        run_op("MULHU -1*-1",   3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        run_op("MULHSU -1*max", 3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33);
        run_op("DIV -7/2",      3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33);
        run_op("REM -7/2",      3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33);
        run_op("DIVU 100/7",    3'b101, 32'd100,        32'd7,        32'd14,       33);
        run_op("REMU 100/7",    3'b111, 32'd100,        32'd7,        32'd2,        33);
        run_op("DIVU 5/0",      3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1);
        run_op("REM 5/0",       3'b110, 32'd5,          32'd0,        32'd5,        1);
        run_op("DIV ovf",       3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1);
        run_op("REM ovf",       3'b110, 32'h80000000,   32'hFFFFFFFF, 32'd0,        1);
        // Flush at cycle 10 of a MUL
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.srcA = 32'd11; bus.srcB = 32'd13;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        #1;
        chk("flush busy_before", 32'(bus.busy), 32'd1);
        chk("flush stall", 32'(bus.stall), 32'd0);
        chk("flush valid", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        chk("flush busy_after", 32'(bus.busy), 32'd0);
        chk("flush valid_after", 32'(bus.result_valid), 32'd0);
        chk("flush result_kept", bus.result, 32'd0);
        run_op("DIVU 9/3",      3'b101, 32'd9,          32'd3,        32'd3,        33);
        // Reset at cycle 20 of a DIV
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.srcA = 32'd1000; bus.srcB = 32'd3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset busy", 32'(bus.busy), 32'd0);
        chk("midreset result", bus.result, 32'd0);
        chk("midreset stall", 32'(bus.stall), 32'd0);
        chk("midreset valid", 32'(bus.result_valid), 32'd0);
        @(negedge clk);
        run_op("MUL 3x4",       3'b000, 32'd3,          32'd4,        32'd12,       33);
        run_op("MUL 5x6",       3'b000, 32'd5,          32'd6,        32'd30,       33);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller for the RV32M extension, sitting beside the execute-stage ALU.
- Accepts one M-extension op from EX and runs a shift-add multiplier or restoring divider over XLEN cycles.
- Holds the pipeline via a stall output, then returns a one-cycle result strobe muxed onto the EX result path.
- Special-case divides (by zero, signed overflow) finish in one cycle.

Parameters:
- XLEN, 32, operand/result width; counter width is clog2(XLEN)+1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  EX stage holds a valid M-extension instruction (opcode 0110011, funct7=0000001)
- funct3  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- srcA  in  XLEN  rs1 operand (forwarded)
- srcB  in  XLEN  rs2 operand (forwarded)
- flush  in  1  kill in-flight op (branch mispredict/trap)
- stall  out  1  freeze IF/ID/EX registers
- busy  out  1  FSM not in IDLE
- result  out  XLEN  final value; valid when result_valid=1
- result_valid  out  1  one-cycle completion strobe

Behaviour:
- Reset: state=IDLE, count=0, result=0, result_valid=0, busy=0. Reset wins over every other input, including mid-operation.
- States: IDLE, MUL, DIV, DONE.

IDLE:
- start=1 & flush=0: latch funct3, latch |srcA| / |srcB| per signedness, and record the result sign.
- Move to MUL (funct3[2]=0) or DIV (funct3[2]=1), with count=0.
- DIV special cases go straight to DONE with a preloaded result:
  - divisor=0: DIV/DIVU give all-ones; REM/REMU give srcA.
  - signed DIV/REM with srcA=0x80000000 and srcB=0xFFFFFFFF: DIV gives 0x80000000, REM gives 0.

MUL:
- Each cycle, add the multiplicand into a 2*XLEN accumulator when the multiplier LSB is 1, then shift; count++.
- Move to DONE after XLEN iterations (count==XLEN-1).

DIV:
- Restoring divide, one quotient bit per cycle. The remainder register is XLEN+1 bits to hold the trial subtract sign.
- Move to DONE after XLEN iterations.

DONE:
- result_valid=1 and stall=0 this cycle.
- Result selection:
  - MUL: low XLEN bits of the product.
  - MULH, MULHSU, MULHU: high XLEN bits.
  - DIV/DIVU: quotient; REM/REMU: remainder.
- Sign fixup is applied before the output register:
  - Product is negated if sign(A)^sign(B), with sign taken only for signed operands (MULHSU: A signed, B unsigned).
  - Quotient is negated if sA^sB; remainder takes the sign of the dividend.
- Always returns to IDLE next edge. The pipeline advances on that same edge, so start in the next cycle belongs to a new instruction: no double issue.

Stall, busy, result:
- stall = (IDLE & start & ~flush) | MUL | DIV. Combinational, so the instruction is frozen in its accept cycle.
- busy = state != IDLE.
- result holds its last value until the next DONE. result_valid is registered low in all other states.

Timing:
- Normal op: start seen in IDLE at cycle 0; compute in cycles 1..XLEN; DONE at cycle XLEN+1.
- stall is high for XLEN+1 cycles.
- Special-case divide: DONE at cycle 1; stall is high 1 cycle.

Flush:
- In MUL/DIV/DONE: next state IDLE, no result_valid, stall drops in the same cycle flush is seen.
- In IDLE: start is ignored.

Other rules:
- Back-to-back ops: a new start is legal in the cycle after DONE.
- Operand changes on srcA/srcB after acceptance are ignored.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> stall high 33 cycles; result_valid at cycle 33 with result=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with result_valid at cycle 1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush asserted at cycle 10 of a MUL -> stall low that cycle, no result_valid, busy=0 next cycle; a new DIVU 9/3 started immediately after -> 3.
- Reset asserted at cycle 20 of a DIV -> next cycle state IDLE, result=0, stall=0 with start=0. Two back-to-back MULs (3x4, 5x6) -> results 12 then 30, each strobed exactly once.
